// File: rtl/led_fade_driver.sv
// LED fade driver: per-LED PWM output stage with a decaying "trail" glow.
// A set pattern bit lights its LED at full level immediately; a cleared bit
// fades the level down by FADE_STEP every FADE_DIV cycles until it reaches 0.
// Optional build macro LED_GAMMA_EN: duty = (level*level) >> PWM_BITS instead
// of duty = level.
module led_fade_driver #(
  parameter int unsigned NUM_LEDS  = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_DIV  = 46875,
  parameter int unsigned FADE_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic [NUM_LEDS-1:0] pattern,
  output logic [NUM_LEDS-1:0] leds,
  output logic                status_led,
  output logic                fade_tick
);

  localparam int unsigned PWM_W  = PWM_BITS;
  localparam int unsigned FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [PWM_W-1:0]  PWM_MAX   = '1;
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);
  localparam logic [PWM_W-1:0]  STEP      = PWM_W'(FADE_STEP);

  logic [PWM_W-1:0]                 pwm_cnt;
  logic [FADE_W-1:0]                fade_cnt;
  logic                             fade_term_c;
  logic                             pwm_wrap_c;
  logic [NUM_LEDS-1:0][PWM_W-1:0]   level_q;
  logic [NUM_LEDS-1:0][PWM_W-1:0]   level_nxt_c;
  logic [NUM_LEDS-1:0][PWM_W-1:0]   duty_q;
  logic [NUM_LEDS-1:0][PWM_W-1:0]   duty_load_c;
  logic [NUM_LEDS-1:0]              leds_nxt_c;

  // Terminal counts: decay strobe and PWM period wrap
  always_comb begin
    fade_term_c = (fade_cnt == FADE_LAST);
    pwm_wrap_c  = (pwm_cnt == PWM_MAX);
  end

  // Free-running PWM phase and decay-interval counters; fade_tick follows the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
      fade_tick <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_W'(1);
      fade_cnt  <= fade_term_c ? '0 : fade_cnt + FADE_W'(1);
      fade_tick <= fade_term_c;
    end
  end

  // Next brightness level: not-ready clears, pattern sets max, strobe decays with floor at 0
  always_comb begin
    level_nxt_c = level_q;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      if (!ready) begin
        level_nxt_c[i] = '0;
      end else if (pattern[i]) begin
        level_nxt_c[i] = PWM_MAX;
      end else if (fade_term_c) begin
        if (32'(level_q[i]) > FADE_STEP) begin
          level_nxt_c[i] = level_q[i] - STEP;
        end else begin
          level_nxt_c[i] = '0;
        end
      end
    end
  end

`ifdef LED_GAMMA_EN
  logic [NUM_LEDS-1:0][2*PWM_W-1:0] sq_c;

  // Gamma-corrected duty: square of the level, truncated to the upper half
  always_comb begin
    sq_c        = '0;
    duty_load_c = '0;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      sq_c[i]        = (2*PWM_W)'(level_q[i]) * (2*PWM_W)'(level_q[i]);
      duty_load_c[i] = PWM_W'(sq_c[i] >> PWM_W);
    end
  end
`else
  // Linear duty: level is used directly
  always_comb begin
    duty_load_c = level_q;
  end
`endif

  // Level register, and duty latched only at the period wrap so each period is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      duty_q  <= '0;
    end else begin
      level_q <= level_nxt_c;
      if (!ready) begin
        duty_q <= '0;
      end else if (pwm_wrap_c) begin
        duty_q <= duty_load_c;
      end
    end
  end

  // PWM compare, gated by ready so a ready drop blanks the pins on the next edge
  always_comb begin
    leds_nxt_c = '0;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      leds_nxt_c[i] = ready && (pwm_cnt < duty_q[i]);
    end
  end

  // Registered pin drive and "not ready" indicator
  always_ff @(posedge clk) begin
    if (rst) begin
      leds       <= '0;
      status_led <= 1'b1;
    end else begin
      leds       <= leds_nxt_c;
      status_led <= ~ready;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: directed scenarios plus randomized stimulus,
// every cycle compared against a cycle-count based behavioural model.
module tb_led_fade_driver;

  localparam int unsigned NL   = 4;
  localparam int unsigned PB   = 4;
  localparam int unsigned FD   = 8;
  localparam int unsigned FS   = 4;
  localparam int          PER  = 16;
  localparam int          LMAX = 15;

`ifdef LED_GAMMA_EN
  localparam int G15 = 14;
  localparam int G11 = 7;
  localparam int G7  = 3;
  localparam int G3  = 0;
`else
  localparam int G15 = 15;
  localparam int G11 = 11;
  localparam int G7  = 7;
  localparam int G3  = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic [NL-1:0] pattern;
  logic [NL-1:0] leds;
  logic          status_led;
  logic          fade_tick;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_LEDS (NL),
    .PWM_BITS (PB),
    .FADE_DIV (FD),
    .FADE_STEP(FS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .pattern   (pattern),
    .leds      (leds),
    .status_led(status_led),
    .fade_tick (fade_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: time since reset drives both the PWM phase and decay schedule
  int          m_t;
  int          m_level[NL];
  int          m_duty[NL];
  bit [NL-1:0] m_leds;
  bit          m_tick;
  bit          m_status;

  function automatic int shape(input int l);
`ifdef LED_GAMMA_EN
    return (l * l) / PER;
`else
    return l;
`endif
  endfunction

  task automatic model_edge();
    int phase;
    bit strobe;
    if (rst) begin
      m_t = 0;
      m_leds = '0;
      m_tick = 1'b0;
      m_status = 1'b1;
      for (int i = 0; i < NL; i++) begin
        m_level[i] = 0;
        m_duty[i] = 0;
      end
    end else begin
      phase  = m_t % PER;
      strobe = ((m_t % FD) == FD - 1);
      m_tick = strobe;
      m_status = !ready;
      for (int i = 0; i < NL; i++) begin
        m_leds[i] = ready && (phase < m_duty[i]);
        if (!ready) m_duty[i] = 0;
        else if (phase == PER - 1) m_duty[i] = shape(m_level[i]);
        if (!ready) m_level[i] = 0;
        else if (pattern[i]) m_level[i] = LMAX;
        else if (strobe) m_level[i] = (m_level[i] > FS) ? m_level[i] - FS : 0;
      end
      m_t++;
    end
  endtask

  task automatic check_all();
    check_eq("leds", leds, m_leds);
    check_eq("status_led", status_led, m_status);
    check_eq("fade_tick", fade_tick, m_tick);
    for (int i = 0; i < NL; i++) begin
      check_eq($sformatf("level%0d", i), dut.level_q[i], m_level[i]);
      check_eq($sformatf("duty%0d", i), dut.duty_q[i], m_duty[i]);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int hi;
    int k;
    int prev;
    int seen_or;
    bit found;
    int seq[6];
    seq = '{11, 7, 3, 0, 0, 0};

    // 1. Reset with ready low and pattern all ones
    rst = 1'b1; ready = 1'b0; pattern = 4'hF;
    for (int c = 0; c < 3; c++) step();
    check_eq("rst_leds", leds, 0);
    check_eq("rst_status", status_led, 1);
    check_eq("rst_tick", fade_tick, 0);
    rst = 1'b0;
    seen_or = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      seen_or |= int'(leds);
    end
    check_eq("notready_leds", seen_or, 0);

    // 2. Full on for LED 0
    ready = 1'b1; pattern = 4'b0001;
    step();
    check_eq("full_level0", dut.level_q[0], LMAX);
    for (int c = 0; c < 40; c++) step();
    for (int c = 0; c < PER && (m_t % PER) != 0; c++) step();
    hi = 0; seen_or = 0;
    for (int c = 0; c < PER; c++) begin
      step();
      hi += int'(leds[0]);
      seen_or |= int'(leds[3:1]);
    end
    check_eq("full_highcount", hi, G15);
    check_eq("full_others_off", seen_or, 0);

    // 3. Trail decay after pattern drop
    pattern = 4'b0000;
    k = 0;
    for (int c = 0; c < 80 && k < 6; c++) begin
      step();
      if (m_tick) begin
        check_eq($sformatf("trail%0d", k), dut.level_q[0], seq[k]);
        k++;
      end
    end
    check_eq("trail_ticks_seen", k, 6);

    // 4. Ready drop with level 7
    pattern = 4'b0001;
    step(); step();
    pattern = 4'b0000;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (m_level[0] == 7) found = 1'b1;
    end
    check_eq("reach_level7", found, 1);
    ready = 1'b0;
    step();
    check_eq("drop_leds", leds, 0);
    check_eq("drop_status", status_led, 1);
    check_eq("drop_level0", dut.level_q[0], 0);
    check_eq("drop_duty0", dut.duty_q[0], 0);
    ready = 1'b1;
    seen_or = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      seen_or |= int'(leds);
    end
    check_eq("resume_leds", seen_or, 0);

    // 5. Pattern rise coinciding with the decay strobe at level 11
    pattern = 4'b0010;
    step(); step();
    pattern = 4'b0000;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (m_level[1] == 11) found = 1'b1;
    end
    check_eq("reach_level11", found, 1);
    for (int c = 0; c < FD && (m_t % FD) != FD - 1; c++) step();
    check_eq("collision_pre", dut.level_q[1], 11);
    pattern = 4'b0010;
    step();
    check_eq("collision_level1", dut.level_q[1], LMAX);
    check_eq("collision_tick", fade_tick, 1);

    // 6. Duty shaping at wrap loads, released at two phases to cover all levels
    for (int ph = 0; ph < PER; ph += 8) begin
      pattern = 4'b0001;
      step();
      for (int c = 0; c < 2 * PER && (m_t % PER) != ph; c++) step();
      pattern = 4'b0000;
      for (int c = 0; c < 3 * PER; c++) begin
        prev = m_level[0];
        step();
        if ((m_t % PER) == 0) begin
          case (prev)
            15: check_eq("shape15", dut.duty_q[0], G15);
            11: check_eq("shape11", dut.duty_q[0], G11);
            7:  check_eq("shape7", dut.duty_q[0], G7);
            3:  check_eq("shape3", dut.duty_q[0], G3);
            default: ;
          endcase
        end
      end
    end

    // Randomized traffic: pattern glitches, ready drops, occasional reset
    for (int c = 0; c < 1500; c++) begin
      rst = (($urandom % 97) == 0);
      ready = (($urandom % 20) != 0);
      if (($urandom % 6) == 0) pattern = NL'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
